// File: rtl/scsi_io_arbiter.sv
// Round-robin arbiter sharing the host io-controller sector channel between two
// SCSI target slots; one grant is held for a whole sector transfer.
module scsi_io_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] req_lba_0,
    input  logic [31:0] req_lba_1,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    output logic [1:0]  req_ack,
    input  logic [7:0]  req_buff_din_0,
    input  logic [7:0]  req_buff_din_1,
    output logic [1:0]  req_buff_wr,
    output logic [31:0] io_lba,
    output logic [1:0]  io_rd,
    output logic [1:0]  io_wr,
    input  logic        io_ack,
    output logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        ptr_q, ptr_d;
    logic [31:0] lba_q, lba_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  io_rd_q, io_rd_d;
    logic [1:0]  io_wr_q, io_wr_d;
    logic        tmo_q, tmo_d;

    logic [1:0]  pend;
    logic        win;
    logic [1:0]  win_oh;

    // A slot with rd and wr both set is served as a read.
    assign pend   = req_rd | req_wr;
    assign win    = (pend == 2'b11) ? ptr_q : ~pend[0];
    assign win_oh = win ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            ptr_q   <= 1'b0;
            lba_q   <= 32'd0;
            cnt_q   <= 24'd0;
            io_rd_q <= 2'b00;
            io_wr_q <= 2'b00;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            io_rd_q <= io_rd_d;
            io_wr_q <= io_wr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        io_rd_d = io_rd_q;
        io_wr_d = io_wr_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    grant_d = win_oh;
                    lba_d   = win ? req_lba_1 : req_lba_0;
                    cnt_d   = 24'd0;
                    io_rd_d = req_rd[win] ? win_oh : 2'b00;
                    io_wr_d = req_rd[win] ? 2'b00 : win_oh;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (io_ack) begin
                    io_rd_d = 2'b00;
                    io_wr_d = 2'b00;
                    state_d = ST_XFER;
                end else if (cnt_q >= TIMEOUT - 24'd1) begin
                    io_rd_d = 2'b00;
                    io_wr_d = 2'b00;
                    tmo_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_XFER: begin
                if (!io_ack) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Last owner drops to lowest priority.
                ptr_d   = grant_q[0];
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign io_lba      = lba_q;
    assign io_rd       = io_rd_q;
    assign io_wr       = io_wr_q;
    assign grant       = grant_q;
    assign timeout_err = tmo_q;

    assign req_ack     = ((state_q == ST_ISSUE) || (state_q == ST_XFER)) ?
                         ({2{io_ack}} & grant_q) : 2'b00;
    assign sd_buff_din = (state_q == ST_XFER) ?
                         (grant_q[1] ? req_buff_din_1 : req_buff_din_0) : 8'd0;
    assign req_buff_wr = (state_q == ST_XFER) ? ({2{sd_buff_wr}} & grant_q) : 2'b00;

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Directed and randomized bench for scsi_io_arbiter against a transaction-level
// round-robin model.
module tb_scsi_io_arbiter;

    logic        clk;
    logic        reset_n;
    logic [31:0] req_lba_0, req_lba_1;
    logic [1:0]  req_rd, req_wr, req_ack;
    logic [7:0]  req_buff_din_0, req_buff_din_1;
    logic [1:0]  req_buff_wr;
    logic [31:0] io_lba;
    logic [1:0]  io_rd, io_wr;
    logic        io_ack;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;

    scsi_io_arbiter #(.TIMEOUT(24'd16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_lba_0(req_lba_0), .req_lba_1(req_lba_1),
        .req_rd(req_rd), .req_wr(req_wr), .req_ack(req_ack),
        .req_buff_din_0(req_buff_din_0), .req_buff_din_1(req_buff_din_1),
        .req_buff_wr(req_buff_wr), .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr),
        .io_ack(io_ack), .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_io_rd"}, 32'(io_rd), 32'd0);
        check({tag, "_io_wr"}, 32'(io_wr), 32'd0);
        check({tag, "_io_lba"}, io_lba, 32'd0);
        check({tag, "_req_ack"}, 32'(req_ack), 32'd0);
        check({tag, "_req_buff_wr"}, 32'(req_buff_wr), 32'd0);
        check({tag, "_sd_buff_din"}, 32'(sd_buff_din), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // One full sector transaction from IDLE (called #1 after an edge with
    // requests already applied). Winner and direction come from the model.
    task automatic run_txn(input int ack_delay, input int xfer_len, input bit fixed_data);
        int          w;
        logic        rd;
        logic [1:0]  pend, g;
        logic [31:0] lba;
        logic [7:0]  exp_din;
        pend = req_rd | req_wr;
        if (pend == 2'b11) w = m_ptr;
        else               w = pend[0] ? 0 : 1;
        g   = (w == 0) ? 2'b01 : 2'b10;
        rd  = req_rd[w];
        lba = (w == 0) ? req_lba_0 : req_lba_1;

        @(posedge clk); #1;
        check("issue_grant", 32'(grant), 32'(g));
        check("issue_lba", io_lba, lba);
        check("issue_io_rd", 32'(io_rd), rd ? 32'(g) : 32'd0);
        check("issue_io_wr", 32'(io_wr), rd ? 32'd0 : 32'(g));
        check("issue_req_ack", 32'(req_ack), 32'd0);
        repeat (ack_delay) begin
            @(posedge clk); #1;
            check("wait_strobe", 32'(io_rd | io_wr), 32'(g));
        end
        if (w == 0) req_lba_0 = $urandom; else req_lba_1 = $urandom;
        io_ack = 1'b1; #1;
        check("req_ack", 32'(req_ack), 32'(g));
        req_rd[w] = 1'b0;
        req_wr[w] = 1'b0;

        @(posedge clk); #1;
        check("xfer_strobes", 32'({io_rd, io_wr}), 32'd0);
        check("xfer_grant", 32'(grant), 32'(g));
        check("xfer_lba_held", io_lba, lba);
        for (int i = 0; i < xfer_len; i++) begin
            if (fixed_data) begin
                req_buff_din_0 = 8'hA5;
                req_buff_din_1 = 8'h3C;
            end else begin
                req_buff_din_0 = 8'($urandom);
                req_buff_din_1 = 8'($urandom);
            end
            sd_buff_wr = (i % 2 == 0);
            #1;
            exp_din = (w == 0) ? req_buff_din_0 : req_buff_din_1;
            check("sd_buff_din", 32'(sd_buff_din), 32'(exp_din));
            check("req_buff_wr", 32'(req_buff_wr), sd_buff_wr ? 32'(g) : 32'd0);
            @(posedge clk); #1;
        end
        sd_buff_wr = 1'b0;
        io_ack = 1'b0; #1;
        check("ack_drop", 32'(req_ack), 32'd0);

        @(posedge clk); #1;
        check("gap_grant", 32'(grant), 32'(g));
        check("gap_buff_wr", 32'(req_buff_wr | {2{timeout_err}}), 32'd0);
        @(posedge clk); #1;
        check("idle_grant", 32'(grant), 32'd0);
        m_ptr = 1 - w;
    endtask

    initial begin
        int ty;
        reset_n = 1'b0;
        req_lba_0 = '0; req_lba_1 = '0;
        req_rd = '0; req_wr = '0;
        req_buff_din_0 = '0; req_buff_din_1 = '0;
        io_ack = 1'b0; sd_buff_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        m_ptr = 0;

        // Single read on slot 1, long transfer.
        req_rd = 2'b10; req_lba_1 = 32'h1234;
        run_txn(5, 520, 1'b0);

        // Both slots hammering: strict alternation starting at slot 0.
        for (int k = 0; k < 4; k++) begin
            req_rd = 2'b11;
            check("rr_order", 32'(m_ptr), 32'(k % 2));
            run_txn(1, 3, 1'b0);
        end
        req_rd = 2'b00;

        // Write routing on slot 0 with fixed data bytes.
        req_wr = 2'b01; req_lba_0 = 32'hCAFE_0000;
        run_txn(0, 6, 1'b1);

        // Timeout on slot 0 while slot 1 queues up.
        req_wr = 2'b01; req_lba_0 = 32'h0BAD_0001;
        @(posedge clk); #1;
        check("tmo_io_wr", 32'(io_wr), 32'h1);
        check("tmo_grant", 32'(grant), 32'h1);
        req_rd[1] = 1'b1; req_lba_1 = 32'h0000_5151;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            check("tmo_hold", 32'({io_wr, timeout_err}), 32'h2);
        end
        @(posedge clk); #1;
        check("tmo_drop", 32'(io_wr), 32'd0);
        check("tmo_pulse", 32'(timeout_err), 32'd1);
        check("tmo_gap_grant", 32'(grant), 32'h1);
        @(posedge clk); #1;
        check("tmo_pulse_end", 32'(timeout_err), 32'd0);
        check("tmo_idle_grant", 32'(grant), 32'd0);
        m_ptr = 1;
        check("tmo_next_slot", 32'(req_rd | req_wr), 32'h3);
        run_txn(2, 2, 1'b0);
        run_txn(0, 2, 1'b0);

        // Reset mid-transfer on slot 1.
        req_rd = 2'b10; req_lba_1 = 32'h7777_0001;
        @(posedge clk); #1;
        io_ack = 1'b1; req_rd = 2'b00;
        @(posedge clk); #1;
        sd_buff_wr = 1'b1; #1;
        check("pre_rst_buff_wr", 32'(req_buff_wr), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        io_ack = 1'b0; sd_buff_wr = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_grant", 32'(grant), 32'd0);
        m_ptr = 0;
        req_rd = 2'b11; req_lba_0 = 32'h1; req_lba_1 = 32'h2;
        run_txn(1, 2, 1'b0);
        run_txn(1, 2, 1'b0);

        // rd and wr both set on slot 1: served as read.
        req_rd = 2'b10; req_wr = 2'b10; req_lba_1 = 32'h00AB_CDEF;
        run_txn(3, 2, 1'b0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            for (int s = 0; s < 2; s++) begin
                if (!(req_rd[s] | req_wr[s]) && ($urandom_range(1, 0) == 1)) begin
                    ty = $urandom_range(2, 0);
                    req_rd[s] = (ty != 1);
                    req_wr[s] = (ty != 0);
                    if (s == 0) req_lba_0 = $urandom; else req_lba_1 = $urandom;
                end
            end
            if ((req_rd | req_wr) == 2'b00) begin
                req_wr[0] = 1'b1;
                req_lba_0 = $urandom;
            end
            run_txn($urandom_range(10, 0), $urandom_range(8, 1), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
